// File: rtl/key_conditioner.sv
// Push-button front end: synchronise, debounce and classify each key into a clean
// level plus press/release/long/repeat pulses. Define KEY_AUTOREPEAT_EN for auto-repeat.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk_50MHz,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_CYCLES);
`endif

    typedef enum logic [1:0] {IDLE, HELD, LONGP} hold_state_e;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic              sync_meta;
        logic              sync_q;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic [DEB_W-1:0]  deb_cnt;
        logic [LONG_W-1:0] hold_cnt;
        logic              toggle;
        logic              rise;
        logic              fall;
        logic              long_fire;
        hold_state_e       state;
        hold_state_e       state_nxt;
`ifdef KEY_AUTOREPEAT_EN
        logic [REP_W-1:0]  rep_cnt;
        logic              repeat_q;
        logic              repeat_fire;
`endif

        // Polarity is folded in ahead of the first flop so everything downstream is active-high.
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                sync_meta <= 1'b0;
                sync_q    <= 1'b0;
            end else begin
                sync_meta <= key_raw[i] ^ ACTIVE_LOW;
                sync_q    <= sync_meta;
            end
        end

        assign toggle = (sync_q != level_q) && (deb_cnt == DEB_LAST);
        assign rise   = toggle && !level_q;
        assign fall   = toggle && level_q;

        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt   <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise;
                release_q <= fall;
                if ((sync_q == level_q) || toggle)
                    deb_cnt <= '0;
                else if (deb_cnt != DEB_MAX)
                    deb_cnt <= deb_cnt + 1'b1;
                if (toggle)
                    level_q <= !level_q;
            end
        end

        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n)
                state <= IDLE;
            else
                state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (rise) state_nxt = HELD;
                HELD:    if (fall) state_nxt = IDLE;
                         else if (hold_cnt == LONG_LAST) state_nxt = LONGP;
                LONGP:   if (fall) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // A release in the same cycle as the threshold wins: no long or repeat event.
        always_comb begin
            long_fire = (state == HELD) && !fall && (hold_cnt == LONG_LAST);
`ifdef KEY_AUTOREPEAT_EN
            repeat_fire = long_fire || ((state == LONGP) && !fall && (rep_cnt == REP_LAST));
`endif
        end

        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= long_fire;
                if ((state == IDLE) && rise)
                    hold_cnt <= '0;
                else if ((state == HELD) && (hold_cnt != LONG_MAX))
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt  <= '0;
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= repeat_fire;
                if (repeat_fire)
                    rep_cnt <= '0;
                else if ((state == LONGP) && (rep_cnt != REP_MAX))
                    rep_cnt <= rep_cnt + 1'b1;
            end
        end

        assign key_repeat[i] = repeat_q;
`else
        assign key_repeat[i] = 1'b0;
`endif

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: an active-high and an active-low instance,
// a windowed behavioural model checked every cycle, and directed literal checks.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int NUM_KEYS = 4;
    localparam int DEB      = 4;
    localparam int LONG     = 20;
    localparam int REP      = 5;

    logic       clk_50MHz = 1'b0;
    logic       rst_n;
    logic [3:0] key_raw;
    logic [3:0] key_raw_al;

    logic [3:0] dut_level   [2];
    logic [3:0] dut_press   [2];
    logic [3:0] dut_release [2];
    logic [3:0] dut_long    [2];
    logic [3:0] dut_repeat  [2];

    logic [3:0]  exp_level   [2];
    logic [3:0]  exp_press   [2];
    logic [3:0]  exp_release [2];
    logic [3:0]  exp_long    [2];
    logic [3:0]  exp_repeat  [2];
    logic [15:0] hist [2][4];
    int          age  [2][4];

    int checks = 0;
    int errors = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    key_conditioner #(
        .NUM_KEYS(NUM_KEYS), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .key_raw(key_raw),
        .key_level(dut_level[0]), .key_press(dut_press[0]), .key_release(dut_release[0]),
        .key_long(dut_long[0]), .key_repeat(dut_repeat[0])
    );

    key_conditioner #(
        .NUM_KEYS(NUM_KEYS), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .key_raw(key_raw_al),
        .key_level(dut_level[1]), .key_press(dut_press[1]), .key_release(dut_release[1]),
        .key_long(dut_long[1]), .key_repeat(dut_repeat[1])
    );

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int p = 0; p < 2; p++) begin
            exp_level[p]   = 4'h0;
            exp_press[p]   = 4'h0;
            exp_release[p] = 4'h0;
            exp_long[p]    = 4'h0;
            exp_repeat[p]  = 4'h0;
            for (int k = 0; k < 4; k++) begin
                hist[p][k] = 16'h0;
                age[p][k]  = 0;
            end
        end
    endtask

    // A level flips once the synchronised sample stream (two samples old) has
    // disagreed with it for DEB consecutive samples; events follow from the level history.
    task automatic modelStep();
        logic [3:0] logical [2];
        logical[0] = key_raw;
        logical[1] = ~key_raw_al;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                logic old_l;
                logic new_l;
                logic all_diff;
                old_l = exp_level[p][k];
                hist[p][k] = {hist[p][k][14:0], logical[p][k]};
                all_diff = 1'b1;
                for (int b = 2; b < DEB + 2; b++)
                    if (hist[p][k][b] == old_l) all_diff = 1'b0;
                new_l = all_diff ? !old_l : old_l;
                exp_level[p][k]   = new_l;
                exp_press[p][k]   = new_l && !old_l;
                exp_release[p][k] = old_l && !new_l;
                if (new_l && !old_l)
                    age[p][k] = 0;
                else if (old_l && new_l && age[p][k] < 1000000)
                    age[p][k]++;
                exp_long[p][k] = old_l && new_l && (age[p][k] == LONG);
`ifdef KEY_AUTOREPEAT_EN
                exp_repeat[p][k] = old_l && new_l && (age[p][k] >= LONG) &&
                                   ((age[p][k] - LONG) % REP == 0);
`else
                exp_repeat[p][k] = 1'b0;
`endif
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk_50MHz or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk_50MHz);
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("cmp level d%0d", p),   dut_level[p],   exp_level[p]);
                checkOutput($sformatf("cmp press d%0d", p),   dut_press[p],   exp_press[p]);
                checkOutput($sformatf("cmp release d%0d", p), dut_release[p], exp_release[p]);
                checkOutput($sformatf("cmp long d%0d", p),    dut_long[p],    exp_long[p]);
                checkOutput($sformatf("cmp repeat d%0d", p),  dut_repeat[p],  exp_repeat[p]);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] raw, input logic [3:0] raw_al, input int cycles);
        key_raw    = raw;
        key_raw_al = raw_al;
        repeat (cycles) @(negedge clk_50MHz);
    endtask

    initial begin
        rst_n      = 1'b0;
        key_raw    = 4'hF;
        key_raw_al = 4'hF;
        repeat (3) @(negedge clk_50MHz);
        checkOutput("reset level", dut_level[0], 4'h0);
        checkOutput("reset press", dut_press[0], 4'h0);
        checkOutput("reset level al", dut_level[1], 4'h0);
        @(negedge clk_50MHz);
        #2 rst_n = 1'b1;

        // Keys held through reset appear as fresh presses.
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_50MHz);
            checkOutput("rst rel level", dut_level[0], (i >= 6) ? 4'hF : 4'h0);
            checkOutput("rst rel press", dut_press[0], (i == 6) ? 4'hF : 4'h0);
        end
        applyStimulus(4'h0, 4'hF, 8);
        checkOutput("all released", dut_level[0], 4'h0);

        // Short press on key 0.
        key_raw = 4'h1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_50MHz);
            if (i == 5)  checkOutput("k0 level early", dut_level[0], 4'h0);
            if (i == 6)  checkOutput("k0 press", dut_press[0], 4'h1);
            if (i == 7)  checkOutput("k0 press 1cyc", dut_press[0], 4'h0);
            if (i == 17) checkOutput("k0 level held", dut_level[0], 4'h1);
            if (i == 18) checkOutput("k0 release", dut_release[0], 4'h1);
            if (i == 18) checkOutput("k0 level fell", dut_level[0], 4'h0);
            checkOutput("k0 no long", dut_long[0], 4'h0);
            if (i == 12) key_raw = 4'h0;
        end

        // Glitches on key 1 never reach the level.
        begin
            logic [15:0] glitch;
            glitch = 16'b0000_0000_1010_0111;
            for (int i = 0; i < 16; i++) begin
                key_raw = {2'b00, glitch[i], 1'b0};
                @(negedge clk_50MHz);
                checkOutput("glitch level", dut_level[0], 4'h0);
                checkOutput("glitch press", dut_press[0], 4'h0);
            end
        end
        applyStimulus(4'h0, 4'hF, 4);

        // Long press with auto-repeat on key 2.
        key_raw = 4'h4;
        for (int i = 1; i <= 56; i++) begin
            int k;
            logic rep_hit;
            @(negedge clk_50MHz);
            k = i - 6;
`ifdef KEY_AUTOREPEAT_EN
            rep_hit = (k >= 20) && (k <= 40) && ((k - 20) % 5 == 0);
`else
            rep_hit = 1'b0;
`endif
            if (i == 6)  checkOutput("k2 press", dut_press[0], 4'h4);
            if (i == 50) checkOutput("k2 level held", dut_level[0], 4'h4);
            if (i == 51) checkOutput("k2 release", dut_release[0], 4'h4);
            checkOutput("k2 long", dut_long[0], (k == 20) ? 4'h4 : 4'h0);
            checkOutput("k2 repeat", dut_repeat[0], rep_hit ? 4'h4 : 4'h0);
            if (i == 45) key_raw = 4'h0;
        end

        // Reset in the middle of a key 3 hold.
        key_raw = 4'h8;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_50MHz);
            if (i == 6) checkOutput("k3 press", dut_press[0], 4'h8);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("k3 rst level", dut_level[0], 4'h0);
        checkOutput("k3 rst long", dut_long[0], 4'h0);
        repeat (2) @(negedge clk_50MHz);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_50MHz);
            checkOutput("k3 re-press", dut_press[0], (i == 6) ? 4'h8 : 4'h0);
            checkOutput("k3 re-long", dut_long[0], (i == 26) ? 4'h8 : 4'h0);
        end
        applyStimulus(4'h0, 4'hF, 8);

        // Active-low instance: idle high is released, a low pulse is a press.
        checkOutput("al idle level", dut_level[1], 4'h0);
        key_raw_al = 4'hE;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk_50MHz);
            if (i == 6)  checkOutput("al press", dut_press[1], 4'h1);
            if (i == 6)  checkOutput("al level", dut_level[1], 4'h1);
            if (i == 16) checkOutput("al release", dut_release[1], 4'h1);
            if (i == 10) key_raw_al = 4'hF;
        end

        repeat (3) @(negedge clk_50MHz);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
